elastic_pipe_chain: RTL and testbench

// - Parametrised N-stage pipeline register chain carrying one data word and one control bus per slot.
// - Adds per-stage valid bits, a valid/ready back-pressure handshake (stall) and a per-stage flush (bubble insert).
// - Supersedes the fixed IDEX/EXMEM/MEMWB control/data registers for the CPU datapath.
// - Lets hazard and branch logic freeze or squash in-flight instructions.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_slot.sv | 38 +++
 rtl/elastic_pipe_chain.sv | 127 ++++++++++++
 tb/tb_elastic_pipe_chain.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the CPU pipeline register chain: the per-slot control bus layout
// and the bit positions of its fields.
package pipe_pkg;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       xfer_byte;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    localparam int ALU_OP_LSB     = 0;
    localparam int ALU_OP_MSB     = 2;
    localparam int XFER_BYTE_BIT  = 3;
    localparam int MEM_READ_BIT   = 4;
    localparam int MEM_WRITE_BIT  = 5;
    localparam int REG_WRITE_BIT  = 6;
    localparam int MEM_TO_REG_BIT = 7;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus data/ctrl registers.
// Priority is flush > load > hold; a bubble always carries ctrl=0.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              flush,
    input  logic              prev_valid,
    input  logic [DATA_W-1:0] prev_data,
    input  logic [CTRL_W-1:0] prev_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= prev_valid;
            ctrl  <= prev_valid ? prev_ctrl : '0;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe_chain.sv
// N-stage elastic pipeline register chain with valid/ready back-pressure,
// per-slot flush and a registered occupancy count.
module elastic_pipe_chain
    import pipe_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int DATA_W = 64,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [CTRL_W-1:0]               in_ctrl,
    input  logic [STAGES-1:0]               flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [CTRL_W-1:0]               out_ctrl,
    output logic [STAGES-1:0]               stage_valid,
    output logic [$clog2(STAGES+1)-1:0]     occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic              slot_valid [STAGES];
    logic [DATA_W-1:0] slot_data  [STAGES];
    logic [CTRL_W-1:0] slot_ctrl  [STAGES];
    logic              prev_valid [STAGES];
    logic [DATA_W-1:0] prev_data  [STAGES];
    logic [CTRL_W-1:0] prev_ctrl  [STAGES];
    logic [STAGES:0]   rdy;
    logic              accept;
    logic              xfer;
    logic [OCC_W-1:0]  dropped;
    logic [OCC_W-1:0]  occ;

    // Ready ripples from the output back to the input within one cycle.
    always_comb begin
        logic [STAGES:0] r;
        r = '0;
        r[STAGES] = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            r[STAGES-1-i] = !slot_valid[STAGES-1-i] | r[STAGES-i];
        end
        rdy = r;
    end

    always_comb begin
        prev_valid[0] = in_valid;
        prev_data[0]  = in_data;
        prev_ctrl[0]  = in_ctrl;
        for (int unsigned i = 1; i < STAGES; i++) begin
            prev_valid[i] = slot_valid[i-1];
            prev_data[i]  = slot_data[i-1];
            prev_ctrl[i]  = slot_ctrl[i-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_slot (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (rdy[k]),
            .flush      (flush[k]),
            .prev_valid (prev_valid[k]),
            .prev_data  (prev_data[k]),
            .prev_ctrl  (prev_ctrl[k]),
            .valid      (slot_valid[k]),
            .data       (slot_data[k]),
            .ctrl       (slot_ctrl[k])
        );
    end

    always_comb begin
        stage_valid = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_valid[i] = slot_valid[i];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = slot_valid[STAGES-1];
    assign out_data  = slot_data[STAGES-1];
    assign out_ctrl  = out_valid ? slot_ctrl[STAGES-1] : '0;

    assign accept = in_valid & rdy[0];
    assign xfer   = out_valid & out_ready;

    // A flushed slot loses whatever it would have held next: the incoming
    // instruction when it loads, its own when it holds.
    always_comb begin
        dropped = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (flush[i] && (rdy[i] ? prev_valid[i] : slot_valid[i])) begin
                dropped = dropped + OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ <= '0;
        end else begin
            occ <= occ + OCC_W'(accept) - OCC_W'(xfer) - dropped;
        end
    end

    assign occupancy = occ;

    a_occ_matches_valid: assert property (
        @(posedge clk) disable iff (!reset_n)
        int'(occupancy) == $countones(stage_valid)
    );

    if (CTRL_W == $bits(ctrl_t)) begin : g_bubble_chk
        a_bubble_no_write: assert property (
            @(posedge clk) disable iff (!reset_n)
            !out_valid |-> (!out_ctrl[REG_WRITE_BIT] && !out_ctrl[MEM_WRITE_BIT])
        );
    end

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Directed bench for elastic_pipe_chain: slot-occupancy model compared every cycle,
// plus hand-computed expectations for latency, stall, flush and reset scenarios.
module tb_elastic_pipe_chain;

    localparam int S  = 3;
    localparam int DW = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic [S-1:0]  flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [S-1:0]  stage_valid;
    logic [1:0]    occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] got [$];

    logic          mv [S] = '{default: 1'b0};
    logic [DW-1:0] md [S] = '{default: '0};
    logic [CW-1:0] mc [S] = '{default: '0};

    always #5 clk = ~clk;

    elastic_pipe_chain #(
        .STAGES (S),
        .DATA_W (DW),
        .CTRL_W (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Which occupied slots hand their item forward this cycle: the front one
    // leaves when downstream takes it, others when the slot ahead is or becomes free.
    function automatic logic [S-1:0] model_moving();
        logic [S-1:0] mov;
        mov = '0;
        for (int k = S - 1; k >= 0; k--) begin
            if (k == S - 1) mov[k] = mv[k] && out_ready;
            else            mov[k] = mv[k] && (!mv[k+1] || mov[k+1]);
        end
        return mov;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [S-1:0]  mov;
        logic          take;
        logic          nv [S];
        logic [DW-1:0] nd [S];
        logic [CW-1:0] nc [S];
        if (!reset_n) begin
            for (int k = 0; k < S; k++) begin
                mv[k] = 1'b0; md[k] = '0; mc[k] = '0;
            end
        end else begin
            mov  = model_moving();
            take = in_valid && (!mv[0] || mov[0]);
            for (int k = 0; k < S; k++) begin
                nv[k] = mv[k] && !mov[k]; nd[k] = md[k]; nc[k] = mc[k];
            end
            for (int k = 1; k < S; k++) begin
                if (mov[k-1]) begin
                    nv[k] = 1'b1; nd[k] = md[k-1]; nc[k] = mc[k-1];
                end
            end
            if (take) begin
                nv[0] = 1'b1; nd[0] = in_data; nc[0] = in_ctrl;
            end
            for (int k = 0; k < S; k++) begin
                if (flush[k]) nv[k] = 1'b0;
                mv[k] = nv[k]; md[k] = nd[k]; mc[k] = nc[k];
            end
        end
    end

    always @(negedge clk) begin
        logic [S-1:0] mov;
        logic [S-1:0] exp_sv;
        int           exp_occ;
        #2;
        mov     = model_moving();
        exp_sv  = '0;
        exp_occ = 0;
        for (int k = 0; k < S; k++) begin
            exp_sv[k] = mv[k];
            if (mv[k]) exp_occ++;
        end
        chk("in_ready",    64'(in_ready),    64'(!mv[0] || mov[0]));
        chk("out_valid",   64'(out_valid),   64'(mv[S-1]));
        chk("out_ctrl",    64'(out_ctrl),    64'(mv[S-1] ? mc[S-1] : 8'h00));
        chk("stage_valid", 64'(stage_valid), 64'(exp_sv));
        chk("occupancy",   64'(occupancy),   64'(exp_occ));
        if (mv[S-1]) chk("out_data", out_data, md[S-1]);
        if (reset_n && out_valid && out_ready) got.push_back(out_data);
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h99;
        in_ctrl   = 8'hFF;
        flush     = '0;
        out_ready = 1'b1;

        // Reset held two cycles with a live input.
        repeat (2) @(negedge clk);
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_ctrl",  64'(out_ctrl),  64'(0));
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;

        // Streaming 1..5: first result visible three cycles after presentation.
        got.delete();
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            in_valid = (n < 5);
            in_data  = 64'(n + 1);
            in_ctrl  = 8'hFF;
            #3;
            if (n >= 3 && n <= 7) begin
                chk("stream_valid", 64'(out_valid), 64'(1));
                chk("stream_data",  out_data,       64'(n - 2));
            end else begin
                chk("stream_idle",  64'(out_valid), 64'(0));
            end
        end
        chk("stream_count", 64'(got.size()), 64'(5));

        // Back-pressure: fill, stall four cycles, release.
        got.delete();
        for (int m = 0; m < 13; m++) begin
            @(negedge clk);
            out_ready = (m >= 7);
            in_valid  = (m <= 7);
            in_data   = (m < 3) ? 64'(10 + m) : 64'd13;
            in_ctrl   = 8'(8'h40 + m);
            #3;
            if (m >= 3 && m <= 6) begin
                chk("bp_in_ready",  64'(in_ready),  64'(0));
                chk("bp_occupancy", 64'(occupancy), 64'(3));
                chk("bp_out_data",  out_data,       64'd10);
            end
            if (m == 7) chk("bp_release_ready", 64'(in_ready), 64'(1));
        end
        chk("bp_count", 64'(got.size()), 64'(4));
        if (got.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("bp_order", got[i], 64'(10 + i));
        end

        // Flush slots 0 and 1 holding A,B with C at the output.
        got.delete();
        for (int m = 0; m < 8; m++) begin
            @(negedge clk);
            in_valid  = (m < 3);
            in_data   = (m == 0) ? 64'hC : (m == 1) ? 64'hB : 64'hA;
            in_ctrl   = 8'h5A;
            out_ready = (m >= 4);
            flush     = (m == 3) ? 3'b011 : 3'b000;
            #3;
            if (m == 3) begin
                chk("fl_occ_before", 64'(occupancy),   64'(3));
                chk("fl_sv_before",  64'(stage_valid), 64'(3'b111));
            end
            if (m == 4) begin
                chk("fl_occ_after",  64'(occupancy),   64'(1));
                chk("fl_sv_after",   64'(stage_valid), 64'(3'b100));
                chk("fl_out_data",   out_data,         64'hC);
            end
        end
        chk("fl_count", 64'(got.size()), 64'(1));
        if (got.size() == 1) chk("fl_survivor", got[0], 64'hC);

        // Flush of slot 0 while an input is accepted.
        got.delete();
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'h77; in_ctrl = 8'h11; flush = 3'b001;
        #3;
        chk("fa_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0; flush = '0;
        #3;
        chk("fa_stage_valid", 64'(stage_valid), 64'(0));
        chk("fa_occupancy",   64'(occupancy),   64'(0));
        repeat (3) @(negedge clk);
        #3;
        chk("fa_no_output", 64'(got.size()), 64'(0));

        // Flush of the output slot in the cycle it is consumed.
        got.delete();
        for (int m = 0; m < 5; m++) begin
            @(negedge clk);
            in_valid = (m == 0); in_data = 64'h55; in_ctrl = 8'h22;
            flush    = (m == 3) ? 3'b100 : 3'b000;
            #3;
            if (m == 3) chk("fo_valid", 64'(out_valid), 64'(1));
            if (m == 4) chk("fo_occ",   64'(occupancy), 64'(0));
        end
        chk("fo_count", 64'(got.size()), 64'(1));

        // Asynchronous reset of a full, stalled chain.
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = (m < 3);
            in_data   = 64'(20 + m);
            in_ctrl   = 8'h33;
        end
        chk("ar_full", 64'(occupancy), 64'(3));
        #1 reset_n = 1'b0;
        #1;
        chk("ar_stage_valid", 64'(stage_valid), 64'(0));
        chk("ar_out_valid",   64'(out_valid),   64'(0));
        chk("ar_occupancy",   64'(occupancy),   64'(0));
        chk("ar_in_ready",    64'(in_ready),    64'(1));
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
